camera_downsampler: RTL

- Upstream capture stage between the OV7670 camera bus and the frame buffer M9K.
- Packs the camera's two-byte RGB565 pixels into one RGB332 byte.
- Generates frame-buffer write address and write enable for a SCREEN_WIDTH x SCREEN_HEIGHT frame.
- The VGA-side image processor reads the stored pixels from that buffer.

---
 rtl/cam_pkg.sv | 33 +++
 rtl/rgb565_to_rgb332.sv | 13 +
 rtl/camera_downsampler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared constants, FSM state encoding and RGB332 colour helpers for the
// OV7670 capture path.
package cam_pkg;

  localparam int SCREEN_WIDTH  = 176;
  localparam int SCREEN_HEIGHT = 144;
  localparam int ADDR_W        = 15;
  localparam int NUM_BARS      = 3;
  localparam int BAR_HEIGHT    = SCREEN_HEIGHT / NUM_BARS;

  typedef enum logic [2:0] {
    SYNC_WAIT,
    BLANK,
    LINE_GAP,
    HI,
    LO
  } cam_state_e;

  localparam logic [7:0] RED   = 8'b111_000_00;
  localparam logic [7:0] GREEN = 8'b000_111_00;
  localparam logic [7:0] BLUE  = 8'b000_000_11;

  // Horizontal colour bars, one bar per BAR_HEIGHT stored lines.
  function automatic logic [7:0] bar_colour(input logic [7:0] y);
    if (int'(y) < BAR_HEIGHT) begin
      return RED;
    end else if (int'(y) < 2 * BAR_HEIGHT) begin
      return GREEN;
    end
    return BLUE;
  endfunction

endpackage

// File: rtl/rgb565_to_rgb332.sv
// Packs the camera's two-byte pixel into one RGB332 byte: R=hi[7:5], G=hi[2:0], B=lo[4:3].
module rgb565_to_rgb332 (
  input  logic [7:0] i_hi,
  input  logic [7:0] i_lo,
  output logic [7:0] o_pixel
);

  logic w_unused_bits;

  assign o_pixel       = {i_hi[7:5], i_hi[2:0], i_lo[4:3]};
  assign w_unused_bits = ^{i_hi[4:3], i_lo[7:5], i_lo[2:0]};

endmodule

// File: rtl/camera_downsampler.sv
// OV7670 capture stage: byte-pair packing, frame-buffer addressing and frame-done pulse.
// Define CAMERA_TEST_PATTERN_EN to replace camera colour with horizontal RGB bars.
module camera_downsampler
  import cam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        CAM_DATA,
  input  logic              HREF,
  input  logic              VSYNC,
  output logic [7:0]        PIXEL_OUT,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W_EN,
  output logic [7:0]        X_ADDR,
  output logic [7:0]        Y_ADDR,
  output logic              FRAME_DONE
);

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SCREEN_WIDTH);

  cam_state_e        r_state;
  logic              r_href_prev;
  logic              r_vsync_prev;
  logic              r_line_seen;
  logic [7:0]        r_hi_byte;
  logic [7:0]        r_x;
  logic [7:0]        r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_line_base;

  logic              w_vsync_rise;
  logic              w_vsync_fall;
  logic              w_href_fall;
  logic              w_line_end;
  logic              w_col_ok;
  logic              w_row_ok;
  logic [7:0]        w_pixel;

  assign w_vsync_rise = VSYNC & ~r_vsync_prev;
  assign w_vsync_fall = ~VSYNC & r_vsync_prev;
  assign w_href_fall  = r_href_prev & ~HREF;
  assign w_line_end   = ((r_state == HI) || (r_state == LO)) && w_href_fall && (r_x != 8'd0);
  assign w_col_ok     = int'(r_x) < SCREEN_WIDTH;
  assign w_row_ok     = int'(r_y) < SCREEN_HEIGHT;

`ifdef CAMERA_TEST_PATTERN_EN
  logic w_unused_data;
  assign w_unused_data = ^{CAM_DATA, r_hi_byte};
  assign w_pixel       = bar_colour(r_y);
`else
  rgb565_to_rgb332 u_pack (
    .i_hi    (r_hi_byte),
    .i_lo    (CAM_DATA),
    .o_pixel (w_pixel)
  );
`endif

  // NOTE: all state and outputs use non-blocking assignments and clear on the async reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= SYNC_WAIT;
      r_href_prev  <= 1'b0;
      r_vsync_prev <= 1'b0;
      r_line_seen  <= 1'b0;
      r_hi_byte    <= 8'd0;
      r_x          <= 8'd0;
      r_y          <= 8'd0;
      r_addr       <= '0;
      r_line_base  <= '0;
      PIXEL_OUT    <= 8'd0;
      W_ADDR       <= '0;
      W_EN         <= 1'b0;
      X_ADDR       <= 8'd0;
      Y_ADDR       <= 8'd0;
      FRAME_DONE   <= 1'b0;
    end else begin
      r_href_prev  <= HREF;
      r_vsync_prev <= VSYNC;
      W_EN         <= 1'b0;
      FRAME_DONE   <= 1'b0;

      if (r_state == SYNC_WAIT) begin
        if (VSYNC) begin
          r_state <= BLANK;
        end
      end else if (w_vsync_rise) begin
        // A half pixel in flight is dropped, but a line ending on this very edge still counts.
        r_state     <= BLANK;
        FRAME_DONE  <= r_line_seen | w_line_end;
        r_line_seen <= 1'b0;
      end else if (((r_state == HI) || (r_state == LO)) && !HREF) begin
        r_state <= LINE_GAP;
        if (w_line_end) begin
          r_line_seen <= 1'b1;
          r_x         <= 8'd0;
          if (w_row_ok) begin
            r_y         <= r_y + 8'd1;
            r_line_base <= r_line_base + LINE_STEP;
            r_addr      <= r_line_base + LINE_STEP;
          end
        end
      end else begin
        case (r_state)
          BLANK: begin
            if (w_vsync_fall) begin
              r_state     <= LINE_GAP;
              r_line_seen <= 1'b0;
              r_x         <= 8'd0;
              r_y         <= 8'd0;
              r_addr      <= '0;
              r_line_base <= '0;
              W_ADDR      <= '0;
              X_ADDR      <= 8'd0;
              Y_ADDR      <= 8'd0;
            end
          end
          LINE_GAP, HI: begin
            if (HREF) begin
              r_hi_byte <= CAM_DATA;
              r_state   <= LO;
            end
          end
          LO: begin
            r_state <= HI;
            // Out-of-window pixels are dropped and freeze X and the address counter.
            if (w_col_ok && w_row_ok) begin
              PIXEL_OUT <= w_pixel;
              W_EN      <= 1'b1;
              W_ADDR    <= r_addr;
              X_ADDR    <= r_x;
              Y_ADDR    <= r_y;
              r_x       <= r_x + 8'd1;
              r_addr    <= r_addr + ADDR_W'(1);
            end
          end
          default: r_state <= SYNC_WAIT;
        endcase
      end
    end
  end

endmodule
